// File: rtl/div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : div_ctrl
// Purpose  : Issue/response controller between the EXU and the radix-2 divider.
// Revision : 1.0 - initial release
// ============================================================================
module div_ctrl #(
  parameter int WIDTH = 64,
  parameter int TAG_W = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [1:0]       i_op,
  input  logic             i_word,
  input  logic [WIDTH-1:0] i_src1,
  input  logic [WIDTH-1:0] i_src2,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_result,
  output logic [TAG_W-1:0] o_tag,
  output logic             o_div_start,
  output logic             o_div_flush,
  output logic             o_div_signed,
  output logic             o_div_w,
  output logic [WIDTH-1:0] o_div_dividend,
  output logic [WIDTH-1:0] o_div_divisor,
  input  logic             i_div_busy,
  input  logic             i_div_end_valid,
  output logic             o_div_end_ready,
  input  logic [WIDTH-1:0] i_div_quotient,
  input  logic [WIDTH-1:0] i_div_remainder
);

  localparam int HALF = WIDTH / 2;

  localparam logic [1:0] C_IDLE  = 2'd0;
  localparam logic [1:0] C_START = 2'd1;
  localparam logic [1:0] C_WAIT  = 2'd2;
  localparam logic [1:0] C_RESP  = 2'd3;

  localparam logic [HALF-1:0]  C_MIN_HALF = {1'b1, {(HALF-1){1'b0}}};
  localparam logic [WIDTH-1:0] C_MIN_FULL = {1'b1, {(WIDTH-1){1'b0}}};

  // Op encoding: bit 1 selects remainder, bit 0 selects unsigned.
  function automatic logic [WIDTH-1:0] fmt_result(input logic word,
                                                   input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    r = v;
    if (word) r = {{HALF{v[HALF-1]}}, v[HALF-1:0]};
    return r;
  endfunction

  logic [1:0]       state_q, state_d;
  logic [1:0]       op_q;
  logic             word_q;
  logic [WIDTH-1:0] src1_q;
  logic [WIDTH-1:0] src2_q;
  logic [TAG_W-1:0] tag_q;
  logic [WIDTH-1:0] result_q, result_d;

  logic             w_accept;
  logic             w_in_signed;
  logic             w_in_rem;
  logic [WIDTH-1:0] w_eff1;
  logic [WIDTH-1:0] w_eff2;
  logic             w_div_zero;
  logic             w_min_neg;
  logic             w_neg_one;
  logic             w_overflow;
  logic             w_special;
  logic [WIDTH-1:0] w_special_raw;
  logic             w_div_active;
  logic             w_unsigned_w;
  logic             w_end_take;
  logic [WIDTH-1:0] w_div_sel;

  // Special-case detection works on the effective (W-truncated) operands.
  assign w_accept    = i_in_valid && o_in_ready && !i_flush;
  assign w_in_signed = !i_op[0];
  assign w_in_rem    = i_op[1];
  assign w_eff1      = i_word ? {{HALF{1'b0}}, i_src1[HALF-1:0]} : i_src1;
  assign w_eff2      = i_word ? {{HALF{1'b0}}, i_src2[HALF-1:0]} : i_src2;
  assign w_div_zero  = (w_eff2 == '0);
  assign w_min_neg   = i_word ? (i_src1[HALF-1:0] == C_MIN_HALF) : (i_src1 == C_MIN_FULL);
  assign w_neg_one   = i_word ? (&i_src2[HALF-1:0]) : (&i_src2);
  assign w_overflow  = w_in_signed && w_min_neg && w_neg_one;
  assign w_special   = w_div_zero || w_overflow;

  always_comb begin
    w_special_raw = '0;
    if (w_div_zero) begin
      w_special_raw = w_in_rem ? w_eff1 : {WIDTH{1'b1}};
    end else if (w_overflow) begin
      w_special_raw = w_in_rem ? '0 : w_eff1;
    end
  end

  assign w_div_active = (state_q == C_START) || (state_q == C_WAIT);
  assign w_unsigned_w = word_q && op_q[0];
  assign w_end_take   = (state_q == C_WAIT) && i_div_end_valid && !i_flush;
  assign w_div_sel    = op_q[1] ? i_div_remainder : i_div_quotient;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= C_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush overrides every transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      C_IDLE:  if (w_accept) state_d = w_special ? C_RESP : C_START;
      C_START: state_d = C_WAIT;
      C_WAIT:  if (i_div_end_valid) state_d = C_RESP;
      C_RESP:  if (i_out_ready) state_d = C_IDLE;
      default: state_d = C_IDLE;
    endcase
    if (i_flush) state_d = C_IDLE;
  end

  // Outputs
  always_comb begin
    o_in_ready      = (state_q == C_IDLE) && !i_div_busy;
    o_out_valid     = (state_q == C_RESP);
    o_div_start     = (state_q == C_START);
    o_div_end_ready = w_end_take;
    o_div_flush     = i_flush;
    o_div_signed    = w_div_active && !op_q[0];
    o_div_w         = w_div_active && word_q && !op_q[0];
    o_div_dividend  = '0;
    o_div_divisor   = '0;
    if (w_div_active) begin
      o_div_dividend = w_unsigned_w ? {{HALF{1'b0}}, src1_q[HALF-1:0]} : src1_q;
      o_div_divisor  = w_unsigned_w ? {{HALF{1'b0}}, src2_q[HALF-1:0]} : src2_q;
    end
    o_result = result_q;
    o_tag    = tag_q;
  end

  always_comb begin
    result_d = result_q;
    if (w_accept && w_special) begin
      result_d = fmt_result(i_word, w_special_raw);
    end else if (w_end_take) begin
      result_d = fmt_result(word_q, w_div_sel);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      op_q     <= '0;
      word_q   <= 1'b0;
      src1_q   <= '0;
      src2_q   <= '0;
      tag_q    <= '0;
      result_q <= '0;
    end else begin
      if (w_accept) begin
        op_q   <= i_op;
        word_q <= i_word;
        src1_q <= i_src1;
        src2_q <= i_src2;
        tag_q  <= i_tag;
      end
      result_q <= result_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_ctrl
// Purpose  : Directed scoreboard bench for div_ctrl with a behavioural divider.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_flush = 1'b0;
  logic        i_in_valid = 1'b0;
  logic        o_in_ready;
  logic [1:0]  i_op = 2'b00;
  logic        i_word = 1'b0;
  logic [63:0] i_src1 = '0;
  logic [63:0] i_src2 = '0;
  logic [4:0]  i_tag = '0;
  logic        o_out_valid;
  logic        i_out_ready = 1'b1;
  logic [63:0] o_result;
  logic [4:0]  o_tag;
  logic        o_div_start;
  logic        o_div_flush;
  logic        o_div_signed;
  logic        o_div_w;
  logic [63:0] o_div_dividend;
  logic [63:0] o_div_divisor;
  logic        i_div_busy;
  logic        i_div_end_valid;
  logic        o_div_end_ready;
  logic [63:0] i_div_quotient;
  logic [63:0] i_div_remainder;

  div_ctrl #(.WIDTH(64), .TAG_W(5)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush),
    .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
    .i_op(i_op), .i_word(i_word), .i_src1(i_src1), .i_src2(i_src2), .i_tag(i_tag),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
    .o_result(o_result), .o_tag(o_tag),
    .o_div_start(o_div_start), .o_div_flush(o_div_flush),
    .o_div_signed(o_div_signed), .o_div_w(o_div_w),
    .o_div_dividend(o_div_dividend), .o_div_divisor(o_div_divisor),
    .i_div_busy(i_div_busy), .i_div_end_valid(i_div_end_valid),
    .o_div_end_ready(o_div_end_ready),
    .i_div_quotient(i_div_quotient), .i_div_remainder(i_div_remainder)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [63:0] res;
    logic [4:0]  tag;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;

  // Behavioural divider: sign-extends low halves in 32-bit mode.
  int          div_lat = 3;
  int          div_cnt;
  int          start_cnt = 0;
  logic        last_signed;
  logic        last_w;
  logic [63:0] last_dividend;

  function automatic logic [63:0] sx32(input logic [63:0] v);
    return {{32{v[31]}}, v[31:0]};
  endfunction

  function automatic logic [127:0] model_div(input logic sgn, input logic w,
                                             input logic [63:0] a0, input logic [63:0] b0);
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] q;
    logic [63:0] r;
    a = w ? sx32(a0) : a0;
    b = w ? sx32(b0) : b0;
    if (b == 64'd0) return {64'hFFFF_FFFF_FFFF_FFFF, a};
    if (sgn) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {q, r};
  endfunction

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      i_div_busy      <= 1'b0;
      i_div_end_valid <= 1'b0;
      i_div_quotient  <= '0;
      i_div_remainder <= '0;
      div_cnt         <= 0;
    end else if (o_div_flush) begin
      i_div_busy      <= 1'b0;
      i_div_end_valid <= 1'b0;
    end else if (o_div_start) begin
      i_div_busy      <= 1'b1;
      i_div_end_valid <= 1'b0;
      div_cnt         <= div_lat;
      start_cnt       <= start_cnt + 1;
      last_signed     <= o_div_signed;
      last_w          <= o_div_w;
      last_dividend   <= o_div_dividend;
      {i_div_quotient, i_div_remainder} <= model_div(o_div_signed, o_div_w,
                                                     o_div_dividend, o_div_divisor);
    end else if (i_div_end_valid) begin
      if (o_div_end_ready) begin
        i_div_end_valid <= 1'b0;
        i_div_busy      <= 1'b0;
      end
    end else if (i_div_busy) begin
      if (div_cnt == 0) i_div_end_valid <= 1'b1;
      else div_cnt <= div_cnt - 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%016h expected=0x%016h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [63:0] res, input logic [4:0] t);
    exp_t e;
    e.res = res;
    e.tag = t;
    sb_q.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [1:0] op, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic [4:0] t);
    int n;
    n = 0;
    i_in_valid = 1'b1;
    i_op = op; i_word = w; i_src1 = a; i_src2 = b; i_tag = t;
    while (!o_in_ready && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    chk("accept_ready", 64'(o_in_ready), 64'd1);
    @(posedge i_clk);
    @(negedge i_clk);
    i_in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!o_out_valid && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    chk(tag, 64'(o_out_valid), 64'd1);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s observed=unexpected_result expected=empty_scoreboard", tag);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_result"}, o_result, e.res);
      chk({tag, "_tag"}, 64'(o_tag), 64'(e.tag));
    end
  endtask

  task automatic response(input string tag);
    wait_valid({tag, "_valid"});
    pop_check(tag);
    @(negedge i_clk);
  endtask

  int s0;

  initial begin
    // Reset state
    repeat (2) @(negedge i_clk);
    chk("rst_in_ready", 64'(o_in_ready), 64'd1);
    chk("rst_out_valid", 64'(o_out_valid), 64'd0);
    chk("rst_div_start", 64'(o_div_start), 64'd0);
    chk("rst_result", o_result, 64'd0);
    chk("rst_tag", 64'(o_tag), 64'd0);
    chk("rst_end_ready", 64'(o_div_end_ready), 64'd0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // DIV -20 / 3
    s0 = start_cnt;
    push_exp(64'hFFFF_FFFF_FFFF_FFFA, 5'd7);
    issue(2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 5'd7);
    response("div64");
    chk("div64_starts", 64'(start_cnt - s0), 64'd1);
    chk("div64_signed", 64'(last_signed), 64'd1);
    chk("div64_w", 64'(last_w), 64'd0);

    // REM -20 % 3
    push_exp(64'hFFFF_FFFF_FFFF_FFFE, 5'd8);
    issue(2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 5'd8);
    response("rem64");

    // REMU by zero: bypass, valid one cycle after accept
    s0 = start_cnt;
    push_exp(64'h1234, 5'd9);
    issue(2'b11, 1'b0, 64'h1234, 64'd0, 5'd9);
    chk("remu0_latency", 64'(o_out_valid), 64'd1);
    response("remu0");
    chk("remu0_starts", 64'(start_cnt - s0), 64'd0);

    // DIVW / REMW overflow
    s0 = start_cnt;
    push_exp(64'hFFFF_FFFF_8000_0000, 5'd10);
    issue(2'b00, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 5'd10);
    chk("divw_ovf_latency", 64'(o_out_valid), 64'd1);
    response("divw_ovf");
    push_exp(64'd0, 5'd11);
    issue(2'b10, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 5'd11);
    response("remw_ovf");
    chk("ovf_starts", 64'(start_cnt - s0), 64'd0);

    // DIVUW: zero-extended operands, sign-extended result
    push_exp(64'hFFFF_FFFF_FFFF_FFFE, 5'd12);
    issue(2'b01, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 5'd12);
    response("divuw");
    chk("divuw_w", 64'(last_w), 64'd0);
    chk("divuw_signed", 64'(last_signed), 64'd0);
    chk("divuw_dividend", last_dividend, 64'h0000_0000_FFFF_FFFE);

    // DIVW with garbage upper halves
    push_exp(64'hFFFF_FFFF_FFFF_FFFA, 5'd13);
    issue(2'b00, 1'b1, 64'h1234_5678_FFFF_FFEC, 64'hABCD_0000_0000_0003, 5'd13);
    response("divw");
    chk("divw_w", 64'(last_w), 64'd1);
    chk("divw_dividend", last_dividend, 64'h1234_5678_FFFF_FFEC);

    // REMUW by zero (low half zero): remainder sign-extended from bit 31
    push_exp(64'hFFFF_FFFF_8000_0005, 5'd20);
    issue(2'b11, 1'b1, 64'h0000_0001_8000_0005, 64'hFFFF_FFFF_0000_0000, 5'd20);
    response("remuw0");

    // Backpressure
    i_out_ready = 1'b0;
    push_exp(64'd100, 5'd14);
    issue(2'b01, 1'b0, 64'd1000, 64'd10, 5'd14);
    wait_valid("bp_valid");
    for (int i = 0; i < 10; i++) begin
      @(negedge i_clk);
      chk("bp_hold_valid", 64'(o_out_valid), 64'd1);
      chk("bp_hold_result", o_result, 64'd100);
      chk("bp_hold_tag", 64'(o_tag), 64'd14);
      chk("bp_in_ready", 64'(o_in_ready), 64'd0);
    end
    i_out_ready = 1'b1;
    response("bp");
    chk("bp_idle_ready", 64'(o_in_ready), 64'd1);

    // Flush while the divider is working
    div_lat = 20;
    issue(2'b00, 1'b0, 64'd50, 64'd5, 5'd3);
    repeat (3) @(negedge i_clk);
    chk("fl_wait_busy", 64'(i_div_busy), 64'd1);
    i_flush = 1'b1;
    #1;
    chk("fl_div_flush", 64'(o_div_flush), 64'd1);
    chk("fl_no_end_ready", 64'(o_div_end_ready), 64'd0);
    @(negedge i_clk);
    i_flush = 1'b0;
    chk("fl_div_flush_low", 64'(o_div_flush), 64'd0);
    for (int i = 0; i < 5; i++) begin
      chk("fl_no_valid", 64'(o_out_valid), 64'd0);
      chk("fl_idle_ready", 64'(o_in_ready), 64'd1);
      @(negedge i_clk);
    end
    div_lat = 3;
    push_exp(64'd14, 5'd15);
    issue(2'b01, 1'b0, 64'd100, 64'd7, 5'd15);
    response("after_flush");

    // Flush in RESP discards the held result
    i_out_ready = 1'b0;
    issue(2'b00, 1'b0, 64'd5, 64'd0, 5'd16);
    chk("flresp_valid", 64'(o_out_valid), 64'd1);
    chk("flresp_result", o_result, 64'hFFFF_FFFF_FFFF_FFFF);
    i_flush = 1'b1;
    @(negedge i_clk);
    i_flush = 1'b0;
    chk("flresp_dropped", 64'(o_out_valid), 64'd0);
    i_out_ready = 1'b1;

    // Flush together with valid in IDLE: op must not be accepted
    i_flush = 1'b1;
    i_in_valid = 1'b1;
    i_op = 2'b00; i_word = 1'b0; i_src1 = 64'd9; i_src2 = 64'd0; i_tag = 5'd17;
    @(negedge i_clk);
    i_flush = 1'b0;
    i_in_valid = 1'b0;
    chk("flidle_no_valid", 64'(o_out_valid), 64'd0);
    chk("flidle_ready", 64'(o_in_ready), 64'd1);
    @(negedge i_clk);
    chk("flidle_no_valid2", 64'(o_out_valid), 64'd0);

    // Asynchronous reset mid-operation
    div_lat = 20;
    issue(2'b01, 1'b0, 64'd50, 64'd5, 5'd18);
    repeat (3) @(negedge i_clk);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(o_out_valid), 64'd0);
    chk("arst_div_start", 64'(o_div_start), 64'd0);
    chk("arst_in_ready", 64'(o_in_ready), 64'd1);
    chk("arst_result", o_result, 64'd0);
    chk("arst_tag", 64'(o_tag), 64'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    div_lat = 3;
    @(negedge i_clk);

    push_exp(64'd6, 5'd19);
    issue(2'b01, 1'b0, 64'd42, 64'd7, 5'd19);
    response("post_reset");
    chk("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Issue/response controller sitting between the EXU pipeline and the iterative radix-2 divider.
- Accepts RV64M DIV/DIVU/REM/REMU and their W variants over a valid/ready handshake.
- Resolves divide-by-zero and signed overflow locally; otherwise drives the divider start/end handshake.
- Selects quotient or remainder, applies W-op sign-extension, and holds the result until the pipeline accepts it.

Parameters:
- WIDTH, 64: datapath width; must be even.
- TAG_W, 5: width of the destination-register tag carried with the op.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset; asynchronous, active-low.
- i_flush  in  1  pipeline flush; kills any in-flight op.
- i_in_valid  in  1  op valid.
- o_in_ready  out  1  controller can accept an op.
- i_op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
- i_word  in  1  W variant (32-bit op, 64-bit sign-extended result).
- i_src1  in  WIDTH  dividend.
- i_src2  in  WIDTH  divisor.
- i_tag  in  TAG_W  destination tag.
- o_out_valid  out  1  result valid.
- i_out_ready  in  1  pipeline accepts result.
- o_result  out  WIDTH  final result.
- o_tag  out  TAG_W  tag of the result.
- o_div_start  out  1  divider start pulse.
- o_div_flush  out  1  divider flush (= i_flush).
- o_div_signed  out  1  divider signed mode.
- o_div_w  out  1  divider 32-bit mode.
- o_div_dividend  out  WIDTH  divider dividend.
- o_div_divisor  out  WIDTH  divider divisor.
- i_div_busy  in  1  divider busy.
- i_div_end_valid  in  1  divider result valid.
- o_div_end_ready  out  1  divider result consumed.
- i_div_quotient  in  WIDTH  divider quotient.
- i_div_remainder  in  WIDTH  divider remainder.

Behaviour:
- FSM states and transitions:
  - IDLE: wait for i_in_valid.
  - START: o_div_start = 1 for exactly this one cycle; next state is WAIT.
  - WAIT: wait for i_div_end_valid.
  - RESP: o_out_valid = 1; leave when i_out_ready.
- Reset: state = IDLE; operand, tag and result registers = 0; all outputs 0 except o_in_ready = 1.
- o_in_ready = (state == IDLE) && !i_div_busy. Accept = i_in_valid && o_in_ready.
- On accept, register op, word, src1, src2 and tag. Effective operands:
  - W ops take the low 32 bits of src1/src2.
  - 64-bit ops use the full values.
- Special cases are detected at accept and bypass the divider; next state is RESP with the result registered.
  - Divisor == 0: quotient = all ones; remainder = dividend (effective operand, 32-bit for W ops).
  - Signed overflow (DIV/REM, dividend = most negative, divisor = -1; for W ops the test uses 32-bit values): quotient = dividend; remainder = 0.
- Any non-special op goes to START.
- Divider drive, valid in START and WAIT:
  - o_div_signed = op is DIV or REM.
  - The divider sign-extends the low halves whenever o_div_w = 1.
  - Signed W: o_div_w = 1; operands are src1/src2 unchanged.
  - Unsigned W: o_div_w = 0; operands are the low 32 bits zero-extended.
  - 64-bit ops: o_div_w = 0; operands unchanged.
- WAIT, when i_div_end_valid = 1:
  - o_div_end_ready = 1 in the same cycle (combinational).
  - Capture i_div_quotient for DIV/DIVU, i_div_remainder for REM/REMU; next state is RESP.
- W results: o_result = sign-extension of bit 31 of the selected 32-bit value. This applies to unsigned W ops as well, and to special-case results.
- o_result and o_tag come from registers and are stable for the whole RESP period.
- RESP with i_out_ready: next state is IDLE. Back-to-back accept in that same cycle is not allowed; the next op is accepted no earlier than one cycle later.
- Latency, accept at cycle N:
  - Special case: o_out_valid at N+1.
  - Normal: o_div_start at N+1; o_out_valid one cycle after i_div_end_valid.
- Flush has priority over everything in every state:
  - Next state is IDLE; o_out_valid drops the next cycle; any captured result is discarded.
  - o_div_flush = i_flush combinationally; no o_div_end_ready is issued for a flushed op.
- i_flush together with i_in_valid in IDLE: the op is not accepted.
- i_div_end_valid outside WAIT is ignored (o_div_end_ready = 0).
- Reset asserted mid-operation returns every state and register to reset values asynchronously.

Test Plan:
- DIV 64-bit: src1 = -20, src2 = 3 → divider started once with signed = 1, w = 0; o_result = -6 (0xFFFF_FFFF_FFFF_FFFA); tag preserved.
- REMU with divisor 0: src1 = 0x1234, src2 = 0 → no o_div_start; o_out_valid at N+1; o_result = 0x1234.
- DIVW overflow: src1 = 0x0000_0000_8000_0000, src2 = 0xFFFF_FFFF → bypass; o_result = 0xFFFF_FFFF_8000_0000. REMW of the same operands → 0.
- DIVUW: src1 = 0xFFFF_FFFF_FFFF_FFFE, src2 = 1 → divider driven with w = 0, dividend = 0x0000_0000_FFFF_FFFE; o_result = 0xFFFF_FFFF_FFFF_FFFE.
- Backpressure: hold i_out_ready = 0 for 10 cycles after o_out_valid → o_result/o_tag stable; o_in_ready = 0 throughout; accept completes when ready rises.
- Flush in WAIT: assert i_flush while divider busy → o_div_flush pulsed; state returns to IDLE; no o_out_valid; a subsequent DIVU 100/7 → 14.
